// File: rtl/buzz_pkg.sv
// Shared types and constants for the quiz buzzer arbiter.
package buzz_pkg;

    // Round state, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WON     = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    localparam int NUM_PLAYERS  = 4;
    localparam int PLAYER_IDX_W = 2;

    // Debounce counter width; DEBOUNCE_CYCLES is limited to 1..255.
    localparam int DBC_CNT_W    = 8;

endpackage

// File: rtl/buzz_debounce.sv
// One player button: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on a debounced rising edge.
module buzz_debounce
    import buzz_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
    localparam logic [DBC_CNT_W-1:0] CNT_LAST = DBC_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 level_q;
    logic                 level_d;
    logic [DBC_CNT_W-1:0] cnt_q;
    logic [DBC_CNT_W-1:0] cnt_d;
    logic                 press_q;
    logic                 press_d;

    // Count consecutive samples that disagree with the debounced level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DBC_CNT_W'(1);
            end
        end
    end

    // Synchroniser, counter, level and press pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/buzz_arbiter.sv
// Buzzer arbiter: debounced player buttons, one winner per round with
// rotating priority on exact ties, optional answer-window timeout.
module buzz_arbiter
    import buzz_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMER_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PLAYERS-1:0]  btn,
    input  logic                    arm,
    input  logic                    ack,
    input  logic [NUM_PLAYERS-1:0]  lockout_mask,
    input  logic [TIMER_WIDTH-1:0]  timeout_cycles,
    output logic                    playerInputFlag,
    output logic [PLAYER_IDX_W-1:0] firstPlayerFlag,
    output logic                    timed_out,
    output logic                    armed,
    output logic [NUM_PLAYERS-1:0]  btn_level
);

    // First requesting player scanning ptr, ptr+1, ... modulo NUM_PLAYERS.
    function automatic logic [PLAYER_IDX_W-1:0] rr_pick(
        input logic [NUM_PLAYERS-1:0]  req,
        input logic [PLAYER_IDX_W-1:0] ptr
    );
        logic [PLAYER_IDX_W-1:0] idx;
        logic [PLAYER_IDX_W-1:0] sel;
        logic                    found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            idx = ptr + PLAYER_IDX_W'(k);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    logic [NUM_PLAYERS-1:0]  press_w;
    logic [NUM_PLAYERS-1:0]  req_w;
    logic [PLAYER_IDX_W-1:0] pick_w;

    state_e                  state_q;
    state_e                  state_d;
    logic [PLAYER_IDX_W-1:0] rr_q;
    logic [PLAYER_IDX_W-1:0] rr_d;
    logic [NUM_PLAYERS-1:0]  mask_q;
    logic [NUM_PLAYERS-1:0]  mask_d;
    logic [TIMER_WIDTH-1:0]  timer_q;
    logic [TIMER_WIDTH-1:0]  timer_d;
    logic                    timer_en_q;
    logic                    timer_en_d;
    logic                    pif_q;
    logic                    pif_d;
    logic [PLAYER_IDX_W-1:0] first_q;
    logic [PLAYER_IDX_W-1:0] first_d;
    logic                    tmo_q;
    logic                    tmo_d;
    logic                    armed_q;
    logic                    armed_d;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_dbc
        buzz_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_dbc (
            .clk_i   (clk),
            .rst_ni  (rst),
            .btn_i   (btn[i]),
            .level_o (btn_level[i]),
            .press_o (press_w[i])
        );
    end

    // Only fresh presses from players not locked out this round qualify.
    assign req_w  = press_w & ~mask_q;
    assign pick_w = rr_pick(req_w, rr_q);

    // Next-state logic; output registers follow the next state.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        mask_d     = mask_q;
        timer_d    = timer_q;
        timer_en_d = timer_en_q;
        first_d    = first_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = ARMED;
                    mask_d     = lockout_mask;
                    timer_d    = timeout_cycles;
                    timer_en_d = |timeout_cycles;
                end
            end
            ARMED: begin
                if (ack) begin
                    state_d = IDLE;
                end else if (|req_w) begin
                    // A press beats a timer expiring on the same cycle.
                    state_d = WON;
                    first_d = pick_w;
                    rr_d    = pick_w + PLAYER_IDX_W'(1);
                end else if (timer_en_q && (timer_q == TIMER_WIDTH'(1))) begin
                    state_d = TIMEOUT;
                end else if (timer_en_q) begin
                    timer_d = timer_q - TIMER_WIDTH'(1);
                end
            end
            WON: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            TIMEOUT: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pif_d   = (state_d == WON);
        tmo_d   = (state_d == TIMEOUT);
        armed_d = (state_d == ARMED);
        if (state_d != WON) begin
            first_d = '0;
        end
    end

    // State, round bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            mask_q     <= '0;
            timer_q    <= '0;
            timer_en_q <= 1'b0;
            pif_q      <= 1'b0;
            first_q    <= '0;
            tmo_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            mask_q     <= mask_d;
            timer_q    <= timer_d;
            timer_en_q <= timer_en_d;
            pif_q      <= pif_d;
            first_q    <= first_d;
            tmo_q      <= tmo_d;
            armed_q    <= armed_d;
        end
    end

    assign playerInputFlag = pif_q;
    assign firstPlayerFlag = first_q;
    assign timed_out       = tmo_q;
    assign armed           = armed_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Directed bench for buzz_arbiter with default parameters
// (DEBOUNCE_CYCLES=16, TIMER_WIDTH=16).
module tb_buzz_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  btn;
    logic        arm;
    logic        ack;
    logic [3:0]  lockout_mask;
    logic [15:0] timeout_cycles;
    logic        playerInputFlag;
    logic [1:0]  firstPlayerFlag;
    logic        timed_out;
    logic        armed;
    logic [3:0]  btn_level;

    int total;
    int bad;

    buzz_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .btn             (btn),
        .arm             (arm),
        .ack             (ack),
        .lockout_mask    (lockout_mask),
        .timeout_cycles  (timeout_cycles),
        .playerInputFlag (playerInputFlag),
        .firstPlayerFlag (firstPlayerFlag),
        .timed_out       (timed_out),
        .armed           (armed),
        .btn_level       (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait n rising edges, then step 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm_round(input logic [3:0] mask, input logic [15:0] tmo);
        arm            = 1'b1;
        lockout_mask   = mask;
        timeout_cycles = tmo;
        tick(1);
        arm            = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_lvl;
        logic seen_win;
        total = 0;
        bad   = 0;
        rst = 1'b0; btn = 4'b0; arm = 1'b0; ack = 1'b0;
        lockout_mask = 4'b0; timeout_cycles = 16'd0;

        // Reset state
        tick(3);
        chk("rst_pif", playerInputFlag, 1'b0);
        chk("rst_fpf", firstPlayerFlag, 2'd0);
        chk("rst_tmo", timed_out, 1'b0);
        chk("rst_armed", armed, 1'b0);
        chk("rst_lvl", btn_level, 4'b0);
        rst = 1'b1;
        tick(2);

        // Tie 1+3 with rr_ptr=0 -> winner 1
        arm_round(4'b0000, 16'd0);
        chk("tie1_armed", armed, 1'b1);
        btn = 4'b1010;
        tick(19);
        chk("tie1_pif", playerInputFlag, 1'b1);
        chk("tie1_fpf", firstPlayerFlag, 2'd1);
        btn = 4'b0;
        ack_pulse();
        chk("tie1_ack_pif", playerInputFlag, 1'b0);
        tick(20);

        // Same tie with rr_ptr=2 -> winner 3
        arm_round(4'b0000, 16'd0);
        btn = 4'b1010;
        tick(19);
        chk("tie2_pif", playerInputFlag, 1'b1);
        chk("tie2_fpf", firstPlayerFlag, 2'd3);
        btn = 4'b0;
        ack_pulse();
        tick(20);

        // Single press on player 2: flags exactly 19 edges after the btn edge
        arm_round(4'b0000, 16'd0);
        btn = 4'b0100;
        tick(18);
        chk("single_early_pif", playerInputFlag, 1'b0);
        chk("single_lvl", btn_level, 4'b0100);
        tick(1);
        chk("single_pif", playerInputFlag, 1'b1);
        chk("single_fpf", firstPlayerFlag, 2'd2);
        chk("single_armed", armed, 1'b0);
        tick(1);
        btn = 4'b0;
        ack_pulse();
        chk("single_ack_pif", playerInputFlag, 1'b0);
        chk("single_ack_fpf", firstPlayerFlag, 2'd0);
        tick(20);

        // Abort during ARMED keeps rr_ptr=3; arm+ack together in IDLE arms
        arm_round(4'b0000, 16'd0);
        tick(3);
        ack_pulse();
        chk("abort_armed", armed, 1'b0);
        chk("abort_pif", playerInputFlag, 1'b0);
        arm = 1'b1; ack = 1'b1;
        tick(1);
        arm = 1'b0; ack = 1'b0;
        chk("armack_armed", armed, 1'b1);
        btn = 4'b1010;
        tick(19);
        chk("abort_tie_fpf", firstPlayerFlag, 2'd3);
        btn = 4'b0;
        ack_pulse();
        tick(20);

        // Timeout of 100 cycles, then arm ignored in TIMEOUT
        arm_round(4'b0000, 16'd100);
        tick(99);
        chk("tmo99_tmo", timed_out, 1'b0);
        chk("tmo99_armed", armed, 1'b1);
        tick(1);
        chk("tmo100_tmo", timed_out, 1'b1);
        chk("tmo100_armed", armed, 1'b0);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        chk("tmo_arm_ign_armed", armed, 1'b0);
        chk("tmo_arm_ign_tmo", timed_out, 1'b1);
        ack_pulse();
        chk("tmo_ack_tmo", timed_out, 1'b0);
        tick(2);

        // Press landing on the expiry cycle (timeout 30, rr_ptr=0)
        arm_round(4'b0000, 16'd30);
        tick(11);
        btn = 4'b0001;
        tick(18);
        chk("exp_pre_tmo", timed_out, 1'b0);
        chk("exp_pre_armed", armed, 1'b1);
        tick(1);
        chk("exp_pif", playerInputFlag, 1'b1);
        chk("exp_fpf", firstPlayerFlag, 2'd0);
        chk("exp_tmo", timed_out, 1'b0);
        btn = 4'b0;
        ack_pulse();
        tick(20);

        // Lockout of player 0, then player 3 wins
        arm_round(4'b0001, 16'd0);
        btn = 4'b0001;
        tick(25);
        chk("lock_p0_pif", playerInputFlag, 1'b0);
        chk("lock_p0_armed", armed, 1'b1);
        btn = 4'b0;
        tick(20);
        btn = 4'b1000;
        tick(19);
        chk("lock_p3_pif", playerInputFlag, 1'b1);
        chk("lock_p3_fpf", firstPlayerFlag, 2'd3);
        btn = 4'b0;
        ack_pulse();
        tick(20);

        // All players masked: only timeout ends the round
        arm_round(4'b1111, 16'd40);
        btn = 4'b0010;
        tick(39);
        chk("allmask_39_tmo", timed_out, 1'b0);
        tick(1);
        chk("allmask_tmo", timed_out, 1'b1);
        chk("allmask_pif", playerInputFlag, 1'b0);
        btn = 4'b0;
        ack_pulse();
        tick(20);

        // Button held across arm must be released and re-pressed
        btn = 4'b0010;
        tick(20);
        arm_round(4'b0000, 16'd0);
        tick(25);
        chk("held_pif", playerInputFlag, 1'b0);
        chk("held_armed", armed, 1'b1);
        btn = 4'b0;
        tick(20);
        chk("held_rel_lvl", btn_level, 4'b0000);
        btn = 4'b0010;
        tick(19);
        chk("repress_pif", playerInputFlag, 1'b1);
        chk("repress_fpf", firstPlayerFlag, 2'd1);

        // WON ignores further presses and arm
        btn = 4'b0011;
        tick(20);
        chk("won_hold_fpf", firstPlayerFlag, 2'd1);
        chk("won_hold_pif", playerInputFlag, 1'b1);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        chk("won_arm_armed", armed, 1'b0);
        chk("won_arm_pif", playerInputFlag, 1'b1);

        // Asynchronous reset in WON, applied between clock edges
        #1;
        rst = 1'b0;
        #1;
        chk("arst_pif", playerInputFlag, 1'b0);
        chk("arst_fpf", firstPlayerFlag, 2'd0);
        chk("arst_armed", armed, 1'b0);
        chk("arst_tmo", timed_out, 1'b0);
        chk("arst_lvl", btn_level, 4'b0000);
        btn = 4'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2);

        // Bounce: btn[0] toggles every 5 cycles for 200 cycles
        arm_round(4'b0000, 16'd0);
        seen_lvl = 1'b0;
        seen_win = 1'b0;
        for (int i = 0; i < 40; i++) begin
            btn[0] = ~btn[0];
            for (int j = 0; j < 5; j++) begin
                tick(1);
                seen_lvl = seen_lvl | btn_level[0];
                seen_win = seen_win | playerInputFlag;
            end
        end
        chk("bounce_lvl", seen_lvl, 1'b0);
        chk("bounce_win", seen_win, 1'b0);
        chk("bounce_armed", armed, 1'b1);
        ack_pulse();
        chk("bounce_abort_armed", armed, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
